// File: rtl/descr_align_ctrl.sv
// descr_align_ctrl
// Word alignment controller for a 30-bit descrambled GTX receive path.
// Hunts for the frame header by issuing single-cycle bitslip requests,
// declares lock after a run of consecutive header matches, and drops lock
// after a run of consecutive header errors.
//
// Optional build macro: DESCR_ALIGN_POL_EN
//   When defined, a full sweep of all 30 slip positions without lock flips
//   the descrambler polarity (REV) and re-resets the descrambler before
//   settling again. When undefined, REV is tied low.
//
// State table:
//   state       | meaning
//   ST_IDLE     | disabled, descrambler held in reset
//   ST_DRST     | descrambler reset pulse, 2 cycles
//   ST_SETTLE   | discarding SETTLE_CNT valid words after slip/reset
//   ST_HUNT     | counting consecutive header matches towards lock
//   ST_SLIP     | issuing one bitslip request, advancing slip position
//   ST_LOCKED   | aligned, counting header errors

module descr_align_ctrl #(
    parameter int          GOOD_CNT   = 64,
    parameter int          BAD_CNT    = 4,
    parameter int          SETTLE_CNT = 16,
    parameter logic [29:0] HDR_MASK   = 30'h3000_0000,
    parameter logic [29:0] HDR_PAT    = 30'h2000_0000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        EN,
    input  logic        DIN_VALID,
    input  logic [29:0] DIN,
    output logic        BITSLIP,
    output logic        DESCR_RSTn,
    output logic        REV,
    output logic        LOCKED,
    output logic        LOCK_LOST,
    output logic [4:0]  SLIP_CNT,
    output logic [15:0] ERR_CNT
);

    localparam int GW = (GOOD_CNT   > 0) ? $clog2(GOOD_CNT + 1)   : 1;
    localparam int BW = (BAD_CNT    > 0) ? $clog2(BAD_CNT + 1)    : 1;
    localparam int SW = (SETTLE_CNT > 0) ? $clog2(SETTLE_CNT + 1) : 1;

    localparam logic [GW-1:0] GOOD_LAST   = GW'((GOOD_CNT > 0) ? GOOD_CNT - 1 : 0);
    localparam logic [BW-1:0] BAD_LAST    = BW'((BAD_CNT > 0) ? BAD_CNT - 1 : 0);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CNT);
    localparam logic [4:0]    SLIP_MAX    = 5'd29;
    localparam logic [1:0]    DRST_LEN    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRST,
        ST_SETTLE,
        ST_HUNT,
        ST_SLIP,
        ST_LOCKED
    } state_t;

    state_t        state;
    logic [1:0]    drst_cnt;
    logic [SW-1:0] settle_cnt;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic          hdr_match;

    // Header compare on the masked bits of the incoming word
    assign hdr_match = ((DIN & HDR_MASK) == HDR_PAT);

    // Alignment sequencer with registered outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            drst_cnt   <= '0;
            settle_cnt <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            BITSLIP    <= 1'b0;
            DESCR_RSTn <= 1'b0;
            REV        <= 1'b0;
            LOCKED     <= 1'b0;
            LOCK_LOST  <= 1'b0;
            SLIP_CNT   <= '0;
            ERR_CNT    <= '0;
        end else begin
            // Both pulse outputs are single-cycle by construction
            BITSLIP   <= 1'b0;
            LOCK_LOST <= 1'b0;

            if (!EN) begin
                // Disable overrides every other event; slip position,
                // polarity and error count are kept for inspection
                state      <= ST_IDLE;
                drst_cnt   <= '0;
                settle_cnt <= '0;
                good_cnt   <= '0;
                bad_cnt    <= '0;
                DESCR_RSTn <= 1'b0;
                LOCKED     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= ST_DRST;
                        drst_cnt   <= DRST_LEN;
                        DESCR_RSTn <= 1'b0;
                        ERR_CNT    <= '0;
                    end

                    ST_DRST: begin
                        if (drst_cnt == 2'd1) begin
                            state      <= ST_SETTLE;
                            drst_cnt   <= '0;
                            settle_cnt <= SETTLE_INIT;
                            DESCR_RSTn <= 1'b1;
                        end else begin
                            drst_cnt <= drst_cnt - 2'd1;
                        end
                    end

                    ST_SETTLE: begin
                        if (settle_cnt == '0) begin
                            state    <= ST_HUNT;
                            good_cnt <= '0;
                        end else if (DIN_VALID) begin
                            if (settle_cnt == SW'(1)) begin
                                state    <= ST_HUNT;
                                good_cnt <= '0;
                            end
                            settle_cnt <= settle_cnt - SW'(1);
                        end
                    end

                    ST_HUNT: begin
                        if (DIN_VALID) begin
                            if (!hdr_match) begin
                                state    <= ST_SLIP;
                                good_cnt <= '0;
                            end else if (good_cnt == GOOD_LAST) begin
                                state    <= ST_LOCKED;
                                good_cnt <= '0;
                                bad_cnt  <= '0;
                                LOCKED   <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + GW'(1);
                            end
                        end
                    end

                    ST_SLIP: begin
                        BITSLIP <= 1'b1;
                        if (SLIP_CNT == SLIP_MAX) begin
                            SLIP_CNT <= '0;
`ifdef DESCR_ALIGN_POL_EN
                            // Every position tried at this polarity: flip it
                            // and restart the descrambler from a clean state
                            REV        <= ~REV;
                            state      <= ST_DRST;
                            drst_cnt   <= DRST_LEN;
                            DESCR_RSTn <= 1'b0;
`else
                            state      <= ST_SETTLE;
                            settle_cnt <= SETTLE_INIT;
`endif
                        end else begin
                            SLIP_CNT   <= SLIP_CNT + 5'd1;
                            state      <= ST_SETTLE;
                            settle_cnt <= SETTLE_INIT;
                        end
                    end

                    ST_LOCKED: begin
                        if (DIN_VALID) begin
                            if (hdr_match) begin
                                bad_cnt <= '0;
                            end else begin
                                if (ERR_CNT != 16'hFFFF) begin
                                    ERR_CNT <= ERR_CNT + 16'd1;
                                end
                                if (bad_cnt == BAD_LAST) begin
                                    state     <= ST_SLIP;
                                    bad_cnt   <= '0;
                                    LOCKED    <= 1'b0;
                                    LOCK_LOST <= 1'b1;
                                end else begin
                                    bad_cnt <= bad_cnt + BW'(1);
                                end
                            end
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
